// File: rtl/traffic_light_sequencer.sv
// Highway/country-road intersection controller: timed Moore FSM with latched
// pedestrian request, clearance intervals and a night flashing mode.
module traffic_light_sequencer #(
   parameter int CNT_W           = 8,
   parameter int HWY_MIN_GREEN   = 20,
   parameter int CNTRY_MIN_GREEN = 5,
   parameter int CNTRY_MAX_GREEN = 10,
   parameter int YELLOW_TIME     = 3,
   parameter int ALL_RED_TIME    = 1,
   parameter int FLASH_HALF      = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sensor,
   input  logic       ped_req,
   input  logic       flash_en,
   output logic [1:0] hwy_light,
   output logic [1:0] cntry_light,
   output logic       ped_walk,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      HG  = 3'd0,
      HY  = 3'd1,
      AR1 = 3'd2,
      CG  = 3'd3,
      CY  = 3'd4,
      AR2 = 3'd5,
      FL  = 3'd6
   } state_t;

   localparam logic [1:0] LAMP_RED    = 2'b00;
   localparam logic [1:0] LAMP_YELLOW = 2'b01;
   localparam logic [1:0] LAMP_GREEN  = 2'b10;
   localparam logic [1:0] LAMP_DARK   = 2'b11;

   localparam logic [CNT_W-1:0] HWY_MIN_LAST   = CNT_W'(HWY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CNTRY_MIN_LAST = CNT_W'(CNTRY_MIN_GREEN - 1);
   localparam logic [CNT_W-1:0] CNTRY_MAX_LAST = CNT_W'(CNTRY_MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] YELLOW_LAST    = CNT_W'(YELLOW_TIME - 1);
   localparam logic [CNT_W-1:0] ALL_RED_LAST   = CNT_W'(ALL_RED_TIME - 1);
   localparam logic [CNT_W-1:0] FLASH_LAST     = CNT_W'(FLASH_HALF - 1);
   localparam logic [CNT_W-1:0] WALK_LEN       = CNT_W'(CNTRY_MIN_GREEN);

   state_t           cur_st;
   state_t           nxt_st;
   logic [CNT_W-1:0] elapsed;
   logic [CNT_W-1:0] nxt_elapsed;
   logic             phase;
   logic             nxt_phase;
   logic             ped_pending;
   logic             nxt_pending;
   logic             nxt_walk;

   // Dwell counter sticks at all-ones so an indefinitely held HG never wraps.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // Lamp pattern as {hwy, cntry} for a given state and blink phase.
   function automatic logic [3:0] lamps(input state_t s, input logic ph);
      case (s)
         HG:      return {LAMP_GREEN,  LAMP_RED};
         HY:      return {LAMP_YELLOW, LAMP_RED};
         CG:      return {LAMP_RED,    LAMP_GREEN};
         CY:      return {LAMP_RED,    LAMP_YELLOW};
         FL:      return ph ? {LAMP_DARK, LAMP_DARK} : {LAMP_YELLOW, LAMP_RED};
         default: return {LAMP_RED,    LAMP_RED};
      endcase
   endfunction

   always_comb begin
      nxt_st = cur_st;
      case (cur_st)
         HG:  if (elapsed >= HWY_MIN_LAST && (sensor || ped_pending)) nxt_st = HY;
         HY:  if (elapsed == YELLOW_LAST)  nxt_st = AR1;
         AR1: if (elapsed == ALL_RED_LAST) nxt_st = CG;
         CG:  if (elapsed == CNTRY_MAX_LAST || (elapsed >= CNTRY_MIN_LAST && !sensor))
                 nxt_st = CY;
         CY:  if (elapsed == YELLOW_LAST)  nxt_st = AR2;
         AR2: if (elapsed == ALL_RED_LAST) nxt_st = HG;
         FL:  if (!flash_en)               nxt_st = AR2;
         default: nxt_st = HG;
      endcase
      // Night flash pre-empts every normal transition from a legal state.
      if (flash_en && (cur_st inside {HG, HY, AR1, CG, CY, AR2}))
         nxt_st = FL;

      if (nxt_st != cur_st)
         nxt_elapsed = '0;
      else if (cur_st == FL && elapsed == FLASH_LAST)
         nxt_elapsed = '0;
      else
         nxt_elapsed = sat_inc(elapsed);

      if (cur_st == FL && nxt_st == FL)
         nxt_phase = phase ^ (elapsed == FLASH_LAST);
      else
         nxt_phase = 1'b0;

      // A request is only consumed when a country phase actually starts.
      nxt_pending = ped_req | (ped_pending & ~(cur_st == AR1 && nxt_st == CG));
      nxt_walk    = (nxt_st == CG) && (nxt_elapsed < WALK_LEN);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cur_st      <= HG;
         elapsed     <= '0;
         phase       <= 1'b0;
         ped_pending <= 1'b0;
         hwy_light   <= LAMP_GREEN;
         cntry_light <= LAMP_RED;
         ped_walk    <= 1'b0;
      end else begin
         cur_st                   <= nxt_st;
         elapsed                  <= nxt_elapsed;
         phase                    <= nxt_phase;
         ped_pending              <= nxt_pending;
         {hwy_light, cntry_light} <= lamps(nxt_st, nxt_phase);
         ped_walk                 <= nxt_walk;
      end
   end

   assign state = cur_st;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Directed scoreboard bench for traffic_light_sequencer using the short
// timing parameters (HWY 4, CNTRY 2..6, YELLOW 2, ALL_RED 1, FLASH_HALF 2).
module tb_traffic_light_sequencer;

   logic       clk = 1'b0;
   logic       rst, sensor, ped_req, flash_en;
   logic [1:0] hwy_light, cntry_light;
   logic       ped_walk;
   logic [2:0] state;

   typedef struct packed {
      logic [2:0] st;
      logic [1:0] hwy;
      logic [1:0] cntry;
      logic       walk;
   } exp_t;

   exp_t  sb[$];
   string tags[$];
   int    n_total = 0;
   int    n_pass  = 0;

   traffic_light_sequencer #(
      .CNT_W(8), .HWY_MIN_GREEN(4), .CNTRY_MIN_GREEN(2), .CNTRY_MAX_GREEN(6),
      .YELLOW_TIME(2), .ALL_RED_TIME(1), .FLASH_HALF(2)
   ) dut (
      .clk(clk), .rst(rst), .sensor(sensor), .ped_req(ped_req), .flash_en(flash_en),
      .hwy_light(hwy_light), .cntry_light(cntry_light), .ped_walk(ped_walk), .state(state)
   );

   always #5 clk = ~clk;

   // Lamp encoding from the state table: {hwy, cntry}.
   function automatic logic [3:0] exp_lamps(input logic [2:0] s, input logic ph);
      case (s)
         3'd0:    return 4'b10_00;
         3'd1:    return 4'b01_00;
         3'd3:    return 4'b00_10;
         3'd4:    return 4'b00_01;
         3'd6:    return ph ? 4'b11_11 : 4'b01_00;
         default: return 4'b00_00;
      endcase
   endfunction

   // Drive one cycle of inputs, queue the expected post-edge outputs, then
   // pop and compare once the edge has happened.
   task automatic step(input logic r, input logic s, input logic p, input logic f,
                       input logic [2:0] es, input logic ew, input logic eph,
                       input string tag);
      exp_t e;
      exp_t got;
      string t;
      rst = r; sensor = s; ped_req = p; flash_en = f;
      e.st = es;
      {e.hwy, e.cntry} = exp_lamps(es, eph);
      e.walk = ew;
      sb.push_back(e);
      tags.push_back(tag);
      @(posedge clk);
      #1;
      e   = sb.pop_front();
      t   = tags.pop_front();
      got = {state, hwy_light, cntry_light, ped_walk};
      n_total++;
      assert (got === e) n_pass++;
      else $error("FAIL %s: got st=%0d hwy=%b cntry=%b walk=%b, want st=%0d hwy=%b cntry=%b walk=%b",
                  t, got.st, got.hwy, got.cntry, got.walk, e.st, e.hwy, e.cntry, e.walk);
   endtask

   int pat2[16] = '{0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 4, 4, 5};

   initial begin
      rst = 1'b1; sensor = 1'b0; ped_req = 1'b0; flash_en = 1'b0;
      #2;

      // Idle: HG holds forever with no demand.
      step(1, 0, 0, 0, 3'd0, 0, 0, "reset");
      for (int k = 0; k < 30; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "idle_hg");

      // Continuous sensor: full 16-cycle cycle with max-green exit.
      step(1, 1, 0, 0, 3'd0, 0, 0, "reset_t2");
      for (int k = 1; k < 32; k++)
         step(0, 1, 0, 0, 3'(pat2[k % 16]), (k % 16 == 7) || (k % 16 == 8), 0, "sensor_cycle");

      // Late short sensor pulse: immediate HY, min-green exit.
      step(1, 0, 0, 0, 3'd0, 0, 0, "reset_t3");
      for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "t3_wait");
      step(0, 1, 0, 0, 3'd1, 0, 0, "t3_hy0");
      step(0, 1, 0, 0, 3'd1, 0, 0, "t3_hy1");
      step(0, 1, 0, 0, 3'd2, 0, 0, "t3_ar1");
      step(0, 0, 0, 0, 3'd3, 1, 0, "t3_cg0");
      step(0, 0, 0, 0, 3'd3, 1, 0, "t3_cg1");
      step(0, 0, 0, 0, 3'd4, 0, 0, "t3_cy0");
      step(0, 0, 0, 0, 3'd4, 0, 0, "t3_cy1");
      step(0, 0, 0, 0, 3'd5, 0, 0, "t3_ar2");
      for (int k = 0; k < 5; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "t3_hg");

      // Single pedestrian pulse: one country phase, then no repeat.
      step(1, 0, 0, 0, 3'd0, 0, 0, "reset_t4");
      step(0, 0, 1, 0, 3'd0, 0, 0, "t4_req");
      step(0, 0, 0, 0, 3'd0, 0, 0, "t4_hg2");
      step(0, 0, 0, 0, 3'd0, 0, 0, "t4_hg3");
      step(0, 0, 0, 0, 3'd1, 0, 0, "t4_hy0");
      step(0, 0, 0, 0, 3'd1, 0, 0, "t4_hy1");
      step(0, 0, 0, 0, 3'd2, 0, 0, "t4_ar1");
      step(0, 0, 0, 0, 3'd3, 1, 0, "t4_cg0");
      step(0, 0, 0, 0, 3'd3, 1, 0, "t4_cg1");
      step(0, 0, 0, 0, 3'd4, 0, 0, "t4_cy0");
      step(0, 0, 0, 0, 3'd4, 0, 0, "t4_cy1");
      step(0, 0, 0, 0, 3'd5, 0, 0, "t4_ar2");
      for (int k = 0; k < 10; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "t4_no_repeat");

      // Flash entered from the third country-green cycle.
      step(1, 1, 0, 0, 3'd0, 0, 0, "reset_t5");
      for (int k = 1; k < 10; k++)
         step(0, 1, 0, 0, 3'(pat2[k]), (k == 7) || (k == 8), 0, "t5_to_cg");
      step(0, 0, 0, 1, 3'd6, 0, 0, "t5_fl0");
      step(0, 0, 0, 1, 3'd6, 0, 0, "t5_fl1");
      step(0, 0, 0, 1, 3'd6, 0, 1, "t5_fl2");
      step(0, 0, 0, 1, 3'd6, 0, 1, "t5_fl3");
      step(0, 0, 0, 1, 3'd6, 0, 0, "t5_fl4");
      step(0, 0, 0, 1, 3'd6, 0, 0, "t5_fl5");
      step(0, 0, 0, 0, 3'd5, 0, 0, "t5_ar2");
      step(0, 0, 0, 0, 3'd0, 0, 0, "t5_hg");

      // Reset during CY with a pending request drops the request.
      step(1, 0, 0, 0, 3'd0, 0, 0, "reset_t6");
      step(0, 0, 1, 0, 3'd0, 0, 0, "t6_req");
      step(0, 0, 0, 0, 3'd0, 0, 0, "t6_hg2");
      step(0, 0, 0, 0, 3'd0, 0, 0, "t6_hg3");
      step(0, 0, 0, 0, 3'd1, 0, 0, "t6_hy0");
      step(0, 0, 0, 0, 3'd1, 0, 0, "t6_hy1");
      step(0, 0, 0, 0, 3'd2, 0, 0, "t6_ar1");
      step(0, 0, 0, 0, 3'd3, 1, 0, "t6_cg0");
      step(0, 0, 1, 0, 3'd3, 1, 0, "t6_cg1_req");
      step(0, 0, 0, 0, 3'd4, 0, 0, "t6_cy0");
      step(1, 0, 0, 0, 3'd0, 0, 0, "t6_rst_in_cy");
      for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "t6_pending_cleared");

      // Reset beats simultaneous flash and pedestrian request.
      step(1, 0, 1, 1, 3'd0, 0, 0, "rst_beats_flash_ped");
      for (int k = 0; k < 6; k++) step(0, 0, 0, 0, 3'd0, 0, 0, "rst_ped_dropped");

      // Reset restarts the HG minimum even after a long dwell.
      step(1, 1, 0, 0, 3'd0, 0, 0, "rst_hg_restart");
      step(0, 1, 0, 0, 3'd0, 0, 0, "hg_min1");
      step(0, 1, 0, 0, 3'd0, 0, 0, "hg_min2");
      step(0, 1, 0, 0, 3'd0, 0, 0, "hg_min3");
      step(0, 1, 0, 0, 3'd1, 0, 0, "hg_min_exit");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
